// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweep checker.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DRAIN,
      REPORT
   } state_e;

   function automatic int tt_size(input int n_in);
      return 1 << n_in;
   endfunction

   function automatic int cnt_width(input int n_in);
      return n_in + 1;
   endfunction

   function automatic int cnt_lsb(input int ch, input int n_in);
      return ch * (n_in + 1);
   endfunction

endpackage

// File: rtl/tt_delay_line.sv
// Fixed-depth register pipeline; DEPTH=0 degenerates to a wire.
module tt_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         // Clearing every stage also drops any in-flight valid flag.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all input vectors through NUM_DUT implementations and compares each
// response against a latched reference truth table.
module tt_sweep_checker
   import tt_pkg::*;
#(
   parameter int N_IN    = 5,
   parameter int NUM_DUT = 2,
   parameter int DUT_LAT = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [tt_size(N_IN)-1:0]              ref_table,
   output logic [N_IN-1:0]                       dut_in,
   input  logic [NUM_DUT-1:0]                    dut_out,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass,
   output logic [NUM_DUT*tt_size(N_IN)-1:0]      err_mask,
   output logic [NUM_DUT*cnt_width(N_IN)-1:0]    err_cnt
);

   localparam int T          = tt_size(N_IN);
   localparam int CW         = cnt_width(N_IN);
   localparam int DW         = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
   localparam int DRAIN_LAST = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;
   localparam logic [CW-1:0] CNT_MAX = CW'(T);

   state_e            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [T-1:0]      ref_q, ref_d;
   logic              pass_q, pass_d;
   logic              accept;
   logic [N_IN:0]     dly_in, dly_out;
   logic              dly_valid;
   logic [N_IN-1:0]   dly_idx;
   logic [N_IN-1:0]   ref_pos;
   logic [NUM_DUT-1:0] ch_zero;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      drain_d = drain_q;
      ref_d   = ref_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               ref_d   = ref_table;
               vec_d   = '0;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (vec_q == N_IN'(T - 1)) begin
               vec_d   = '0;
               drain_d = '0;
               state_d = (DUT_LAT > 0) ? DRAIN : REPORT;
            end else begin
               vec_d = vec_q + N_IN'(1);
            end
         end
         DRAIN: begin
            if (drain_q == DW'(DRAIN_LAST)) state_d = REPORT;
            else                            drain_d = drain_q + DW'(1);
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The verdict uses next-cycle counts so the final compare is included.
   always_comb begin
      pass_d = pass_q;
      if (accept)
         pass_d = 1'b0;
      else if (state_d == REPORT && state_q != REPORT)
         pass_d = &ch_zero;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         drain_q <= '0;
         ref_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         drain_q <= drain_d;
         ref_q   <= ref_d;
         pass_q  <= pass_d;
      end
   end

   assign dly_in = {state_q == DRIVE, vec_q};

   tt_delay_line #(
      .WIDTH (N_IN + 1),
      .DEPTH (DUT_LAT)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .d_i (dly_in),
      .q_o (dly_out)
   );

   assign dly_valid = dly_out[N_IN];
   assign dly_idx   = dly_out[N_IN-1:0];
   // MSB-first table: entry k lives at bit T-1-k, which is ~k.
   assign ref_pos   = ~dly_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DUT; gi++) begin : g_ch
         logic [T-1:0]  mask_q, mask_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic          mis;

         assign mis = dly_valid & (dut_out[gi] ^ ref_q[ref_pos]);

         always_comb begin
            mask_d = mask_q;
            cnt_d  = cnt_q;
            if (accept) begin
               mask_d = '0;
               cnt_d  = '0;
            end else if (mis) begin
               mask_d[dly_idx] = 1'b1;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               mask_q <= '0;
               cnt_q  <= '0;
            end else begin
               mask_q <= mask_d;
               cnt_q  <= cnt_d;
            end
         end

         assign ch_zero[gi]                       = (cnt_d == '0);
         assign err_mask[gi*T +: T]               = mask_q;
         assign err_cnt[cnt_lsb(gi, N_IN) +: CW]  = cnt_q;
      end
   endgenerate

   assign dut_in = vec_q;
   assign busy   = (state_q == DRIVE) || (state_q == DRAIN);
   assign done   = (state_q == REPORT);
   assign pass   = pass_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed checks of the sweep checker with combinational (latency 0) and
// two-stage registered (latency 2) function models.
module tb_tt_sweep_checker;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start0, start2;
   logic [31:0] ref_table, refw;
   logic [4:0]  dut_in0, dut_in2;
   logic [1:0]  dut_out0, dut_out2;
   logic        busy0, done0, pass0, busy2, done2, pass2;
   logic [63:0] err_mask0, err_mask2;
   logic [11:0] err_cnt0, err_cnt2;
   int          mode_c0, mode_c1;
   logic        use_reg;
   logic [1:0]  pipe1_q, pipe2_q;
   int          n_total = 0;
   int          n_bad = 0;
   int          edges;
   int          seen;

   // mode 0 correct, 1 flipped on vector 5, 2 tied low, 3 inverted
   function automatic logic model_bit(input int mode, input logic [31:0] tbl, input logic [4:0] v);
      logic [4:0] pos;
      logic       fv;
      pos = 5'd31 - v;
      fv  = tbl[pos];
      case (mode)
         1:       model_bit = (v == 5'd5) ? ~fv : fv;
         2:       model_bit = 1'b0;
         3:       model_bit = ~fv;
         default: model_bit = fv;
      endcase
   endfunction

   assign dut_out0 = {model_bit(mode_c1, refw, dut_in0), model_bit(mode_c0, refw, dut_in0)};

   always @(posedge clk) begin
      pipe1_q <= {2{model_bit(0, refw, dut_in2)}};
      pipe2_q <= pipe1_q;
   end
   assign dut_out2 = use_reg ? pipe2_q : {2{model_bit(0, refw, dut_in2)}};

   tt_sweep_checker #(.N_IN(5), .NUM_DUT(2), .DUT_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .ref_table(ref_table),
      .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
      .pass(pass0), .err_mask(err_mask0), .err_cnt(err_cnt0)
   );

   tt_sweep_checker #(.N_IN(5), .NUM_DUT(2), .DUT_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .ref_table(ref_table),
      .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
      .pass(pass2), .err_mask(err_mask2), .err_cnt(err_cnt2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Starts a sweep on instance inst, returns edges from the start edge to done.
   task automatic do_sweep(input int inst, input bit keep_start, output int n_done);
      @(negedge clk);
      if (inst == 0) start0 = 1'b1;
      else           start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep_start) begin
         start0 = 1'b0;
         start2 = 1'b0;
      end
      chk("busy_after_start", (inst == 0) ? busy0 : busy2, 1);
      chk("dut_in_after_start", (inst == 0) ? dut_in0 : dut_in2, 0);
      n_done = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (keep_start && n == 8) ref_table = 32'h0000_0000;
         if ((inst == 0) ? done0 : done2) begin
            n_done = n;
            break;
         end
      end
      if (n_done < 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      rst       = 1'b1;
      start0    = 1'b0;
      start2    = 1'b0;
      refw      = 32'h52263ECD;
      ref_table = refw;
      mode_c0   = 0;
      mode_c1   = 0;
      use_reg   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dut_in", dut_in0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err_mask", err_mask0, 0);
      chk("rst_err_cnt", err_cnt0, 0);
      rst = 1'b0;

      // both channels correct
      do_sweep(0, 0, edges);
      chk("t1_done_edge", edges, 32);
      chk("t1_err_cnt", err_cnt0, 0);
      chk("t1_err_mask", err_mask0, 0);
      chk("t1_pass", pass0, 1);
      chk("t1_busy_at_done", busy0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t1_done_one_cycle", done0, 0);
      chk("t1_busy_after", busy0, 0);
      chk("t1_pass_holds", pass0, 1);

      // channel 1 wrong only on vector 5
      mode_c1 = 1;
      do_sweep(0, 0, edges);
      chk("t2_done_edge", edges, 32);
      chk("t2_err_mask", err_mask0, 64'h0000_0020_0000_0000);
      chk("t2_err_cnt", err_cnt0, 12'h040);
      chk("t2_pass", pass0, 0);

      // channel 0 stuck low, channel 1 inverted
      mode_c0 = 2;
      mode_c1 = 3;
      do_sweep(0, 0, edges);
      chk("t3_err_cnt", err_cnt0, 12'h810);
      chk("t3_err_mask", err_mask0, 64'hFFFF_FFFF_B37C_644A);
      chk("t3_pass", pass0, 0);

      // latency 2: registered models align, unregistered ones do not
      use_reg = 1'b1;
      do_sweep(1, 0, edges);
      chk("t4_done_edge", edges, 34);
      chk("t4_err_cnt", err_cnt2, 0);
      chk("t4_pass", pass2, 1);
      use_reg = 1'b0;
      do_sweep(1, 0, edges);
      chk("t4_misalign_pass", pass2, 0);
      chk("t4_misalign_seen", (err_cnt2 != 12'h0), 1);
      use_reg = 1'b1;

      // reset in mid-sweep
      mode_c0 = 0;
      mode_c1 = 3;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("t5_dut_in_mid", dut_in0, 10);
      chk("t5_err_cnt_mid", err_cnt0, 12'h280);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_rst_dut_in", dut_in0, 0);
      chk("t5_rst_busy", busy0, 0);
      chk("t5_rst_done", done0, 0);
      chk("t5_rst_err_cnt", err_cnt0, 0);
      chk("t5_rst_err_mask", err_mask0, 0);
      rst  = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (done0) seen++;
      end
      chk("t5_no_done_after_rst", seen, 0);
      mode_c1 = 0;
      do_sweep(0, 0, edges);
      chk("t5_fresh_done_edge", edges, 32);
      chk("t5_fresh_pass", pass0, 1);

      // start held, reference changed mid-sweep
      do_sweep(0, 1, edges);
      chk("t6_done_edge", edges, 32);
      chk("t6_pass_latched_ref", pass0, 1);
      chk("t6_err_cnt", err_cnt0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_gap_busy", busy0, 0);
      chk("t6_gap_done", done0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_restart_busy", busy0, 1);
      chk("t6_restart_dut_in", dut_in0, 0);
      start0 = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
